// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 / stride-2 max-pool over a raster-order pixel
// stream. Horizontal pair maxima of even rows are parked in a half-width line
// buffer; odd rows combine with them to produce one pooled pixel per window.
module maxpool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_SIZE    = 5,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int OUT_SIZE = IN_SIZE / 2;
  localparam int CW       = $clog2(IN_SIZE + 1);
  localparam int IW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST     = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0] POOL_LIM = CW'(2 * OUT_SIZE);

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_line [OUT_SIZE];
  logic [DATA_WIDTH-1:0] r_d_out;
  logic                  r_valid_out;
  logic                  r_frame_done;

  logic                  w_col_in;
  logic                  w_row_in;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_pm;
  logic [DATA_WIDTH-1:0] w_win;

  function automatic logic [DATA_WIDTH-1:0] f_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
    else             return (a > b) ? a : b;
  endfunction

  // A trailing odd row/column (odd IN_SIZE) lies outside every window.
  assign w_col_in   = (r_col < POOL_LIM);
  assign w_row_in   = (r_row < POOL_LIM);
  assign w_col_last = (r_col == LAST);
  assign w_row_last = (r_row == LAST);
  assign w_idx      = IW'(r_col >> 1);
  assign w_pm       = f_max(r_pair, d_in);
  assign w_win      = f_max(r_line[w_idx], w_pm);

  // Raster position of the pixel currently on d_in; advances only on valid_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Left pixel of each horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair <= '0;
    end else if (valid_in && w_col_in && !r_col[0]) begin
      r_pair <= d_in;
    end
  end

  // Even-row pair maxima, consumed by the following odd row.
  always_ff @(posedge clk) begin
    if (valid_in && w_col_in && r_col[0] && w_row_in && !r_row[0]) begin
      r_line[w_idx] <= w_pm;
    end
  end

  // Registered outputs: one pulse per window bottom-right, zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_out      <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_d_out      <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= valid_in && w_col_last && w_row_last;
      if (valid_in && w_col_in && r_col[0] && w_row_in && r_row[0]) begin
        r_d_out     <= w_win;
        r_valid_out <= 1'b1;
      end
    end
  end

  assign d_out      = r_d_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule
